// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, with registered NZCV flags and memory wait states.
module arm_multicycle_controller #(
    parameter int ALUCTRL_W   = 3,
    parameter int FLAG_W      = 4,
    parameter int MEM_WAIT_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [FLAG_W-1:0]    ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 RegByte,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b000);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b001);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b010);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3'b011);
    localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(3'b100);

    state_t              state_q, state_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       rd_is_pc;
    logic       mem_rdy;
    logic       cond_ex;
    logic       no_write;
    logic       unused_rn;
    logic [ALUCTRL_W-1:0] dp_ctrl;

    logic pc_write, ir_write, reg_write, mem_write;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign cmd       = funct[4:1];
    assign rd_is_pc  = (rd == 4'd15);
    assign unused_rn = ^Instr[7:4];
    assign mem_rdy   = (MEM_WAIT_EN == 0) ? 1'b1 : MemReady;

    // Condition check against the registered flags: N=3, Z=2, C=1, V=0.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        dp_ctrl  = ALU_ADD;
        no_write = 1'b0;
        case (cmd)
            4'b0100: dp_ctrl = ALU_ADD;
            4'b0010: dp_ctrl = ALU_SUB;
            4'b0000: dp_ctrl = ALU_AND;
            4'b1100: dp_ctrl = ALU_ORR;
            4'b0001: dp_ctrl = ALU_EOR;
            4'b1010: begin
                dp_ctrl  = ALU_SUB;
                no_write = 1'b1;
            end
            default: begin
                dp_ctrl  = ALU_ADD;
                no_write = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        flags_d    = flags_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        AdrSrc     = 1'b0;
        RegByte    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_rdy) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else begin
                    state_d  = FETCH;
                end
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
                RegByte    = funct[2];
                state_d    = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                RegByte = funct[2];
                state_d = mem_rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegByte   = funct[2];
                reg_write = cond_ex;
                pc_write  = cond_ex & rd_is_pc;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                RegByte   = funct[2];
                mem_write = cond_ex;
                state_d   = mem_rdy ? FETCH : MEMWR;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
                ALUControl = dp_ctrl;
                if (funct[0] && cond_ex) begin
                    flags_d = ALUFlags;
                end
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_write = cond_ex & ~no_write;
                pc_write  = cond_ex & ~no_write & rd_is_pc;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_write  = cond_ex;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Enables are masked by reset directly so an in-flight write drops before any edge.
    assign PCWrite  = pc_write  & ~reset;
    assign IRWrite  = ir_write  & ~reset;
    assign RegWrite = reg_write & ~reset;
    assign MemWrite = mem_write & ~reset;

    assign ImmSrc = op;
    assign RegSrc = {(op == 2'b01), (op == 2'b10)};
    assign State  = state_q;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Directed bench for arm_multicycle_controller: instruction sequences with hand-computed
// state traces and control values, sampled mid-cycle.
module tb_arm_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegByte;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    int total = 0;
    int bad   = 0;

    arm_multicycle_controller #(.ALUCTRL_W(3), .FLAG_W(4), .MEM_WAIT_EN(1)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegByte(RegByte), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 2 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; MemReady = 1'b1; Instr = 20'hE0821; ALUFlags = 4'b0000;
        repeat (2) @(posedge clk);
        #3;
        total++; if (State !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", State); end
        total++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin bad++; $display("FAIL rst_enables got=%b exp=0000", {PCWrite, IRWrite, RegWrite, MemWrite}); end
        total++; if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 7'b0_01_10_10) begin bad++; $display("FAIL rst_muxes got=%b exp=0011010", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_fetch_wait();
        MemReady = 1'b0;
        #1;
        total++; if ({IRWrite, PCWrite} !== 2'b00) begin bad++; $display("FAIL fetch_wait_en got=%b exp=00", {IRWrite, PCWrite}); end
        tick(); tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL fetch_hold got=%0d exp=0", State); end
        MemReady = 1'b1;
        #1;
        total++; if ({IRWrite, PCWrite} !== 2'b11) begin bad++; $display("FAIL fetch_ready_en got=%b exp=11", {IRWrite, PCWrite}); end
        tick();
        total++; if (State !== 4'd1) begin bad++; $display("FAIL fetch_to_decode got=%0d exp=1", State); end
        // Finish the ADD already in flight: EXECR, ALUWB.
        tick(); tick(); tick();
    endtask

    task automatic test_add();
        Instr = 20'hE0821; MemReady = 1'b1; ALUFlags = 4'b1111;
        #1;
        total++; if (State !== 4'd0) begin bad++; $display("FAIL add_s0 got=%0d exp=0", State); end
        tick();
        total++; if (State !== 4'd1 || ResultSrc !== 2'b10) begin bad++; $display("FAIL add_decode state=%0d rs=%b exp=1/10", State, ResultSrc); end
        tick();
        total++; if (State !== 4'd6 || ALUControl !== 3'b000 || RegWrite !== 1'b0 || ALUSrcB !== 2'b00) begin bad++; $display("FAIL add_execr state=%0d ctl=%b rw=%b srcb=%b exp=6/000/0/00", State, ALUControl, RegWrite, ALUSrcB); end
        tick();
        total++; if (State !== 4'd8 || RegWrite !== 1'b1 || ResultSrc !== 2'b00 || PCWrite !== 1'b0) begin bad++; $display("FAIL add_aluwb state=%0d rw=%b rs=%b pcw=%b exp=8/1/00/0", State, RegWrite, ResultSrc, PCWrite); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL add_done got=%0d exp=0", State); end
        // ADD has S=0, so flags stay clear and BEQ must not take.
        Instr = 20'h0A000; ALUFlags = 4'b0000;
        tick(); tick();
        #1;
        total++; if (State !== 4'd9 || PCWrite !== 1'b0) begin bad++; $display("FAIL add_flags_kept state=%0d pcw=%b exp=9/0", State, PCWrite); end
        tick();
    endtask

    task automatic test_subs_beq();
        for (int k = 0; k < 2; k++) begin
            Instr = 20'hE0510; MemReady = 1'b1;
            ALUFlags = (k == 0) ? 4'b0100 : 4'b0000;
            tick(); tick();
            #1;
            total++; if (State !== 4'd6 || ALUControl !== 3'b001) begin bad++; $display("FAIL subs_exec k=%0d state=%0d ctl=%b exp=6/001", k, State, ALUControl); end
            tick();
            ALUFlags = 4'b1011;
            #1;
            total++; if (State !== 4'd8 || RegWrite !== 1'b1) begin bad++; $display("FAIL subs_aluwb k=%0d state=%0d rw=%b exp=8/1", k, State, RegWrite); end
            tick();
            Instr = 20'h0A000;
            tick(); tick();
            #1;
            total++; if (State !== 4'd9 || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01) begin bad++; $display("FAIL beq_muxes k=%0d state=%0d a=%b b=%b exp=9/10/01", k, State, ALUSrcA, ALUSrcB); end
            total++; if (PCWrite !== (k == 0)) begin bad++; $display("FAIL beq_pcwrite k=%0d got=%b exp=%0d", k, PCWrite, (k == 0)); end
            tick();
            total++; if (State !== 4'd0) begin bad++; $display("FAIL beq_done k=%0d got=%0d exp=0", k, State); end
        end
    endtask

    task automatic test_ldrb();
        Instr = 20'hE5D54; MemReady = 1'b1;
        tick(); tick();
        MemReady = 1'b0;
        #1;
        total++; if (State !== 4'd2 || RegByte !== 1'b1 || ALUControl !== 3'b000 || ALUSrcB !== 2'b01) begin bad++; $display("FAIL ldrb_memadr state=%0d rb=%b ctl=%b b=%b exp=2/1/000/01", State, RegByte, ALUControl, ALUSrcB); end
        tick();
        for (int i = 0; i < 4; i++) begin
            MemReady = (i == 3);
            #1;
            total++; if (State !== 4'd3 || AdrSrc !== 1'b1 || RegByte !== 1'b1 || RegWrite !== 1'b0) begin bad++; $display("FAIL ldrb_memrd i=%0d state=%0d adr=%b rb=%b rw=%b exp=3/1/1/0", i, State, AdrSrc, RegByte, RegWrite); end
            tick();
        end
        #1;
        total++; if (State !== 4'd4 || ResultSrc !== 2'b01 || RegWrite !== 1'b1 || RegByte !== 1'b1 || PCWrite !== 1'b0) begin bad++; $display("FAIL ldrb_memwb state=%0d rs=%b rw=%b rb=%b pcw=%b exp=4/01/1/1/0", State, ResultSrc, RegWrite, RegByte, PCWrite); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL ldrb_done got=%0d exp=0", State); end
    endtask

    task automatic test_strne();
        Instr = 20'hE0510; MemReady = 1'b1; ALUFlags = 4'b0100;
        tick(); tick(); tick(); tick();
        Instr = 20'h15850; ALUFlags = 4'b0000;
        tick(); tick();
        MemReady = 1'b0;
        #1;
        total++; if (State !== 4'd2 || ALUControl !== 3'b000) begin bad++; $display("FAIL strne_memadr state=%0d ctl=%b exp=2/000", State, ALUControl); end
        tick();
        for (int i = 0; i < 3; i++) begin
            MemReady = (i == 2);
            #1;
            total++; if (State !== 4'd5 || MemWrite !== 1'b0 || AdrSrc !== 1'b1) begin bad++; $display("FAIL strne_memwr i=%0d state=%0d mw=%b adr=%b exp=5/0/1", i, State, MemWrite, AdrSrc); end
            tick();
        end
        total++; if (State !== 4'd0) begin bad++; $display("FAIL strne_done got=%0d exp=0", State); end
    endtask

    task automatic test_cmp();
        Instr = 20'hE1500; MemReady = 1'b1; ALUFlags = 4'b1000;
        tick(); tick();
        #1;
        total++; if (State !== 4'd6 || ALUControl !== 3'b001) begin bad++; $display("FAIL cmp_exec state=%0d ctl=%b exp=6/001", State, ALUControl); end
        tick();
        ALUFlags = 4'b0000;
        #1;
        total++; if (State !== 4'd8 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin bad++; $display("FAIL cmp_aluwb state=%0d rw=%b pcw=%b exp=8/0/0", State, RegWrite, PCWrite); end
        tick();
        // BMI takes only if CMP loaded N=1 into the flag register.
        Instr = 20'h4A000;
        tick(); tick();
        #1;
        total++; if (State !== 4'd9 || PCWrite !== 1'b1) begin bad++; $display("FAIL cmp_flags_bmi state=%0d pcw=%b exp=9/1", State, PCWrite); end
        tick();
    endtask

    task automatic test_dp_variants();
        // ADD R15: writes both the register file and PC.
        Instr = 20'hE082F; MemReady = 1'b1;
        tick(); tick(); tick();
        #1;
        total++; if (State !== 4'd8 || RegWrite !== 1'b1 || PCWrite !== 1'b1) begin bad++; $display("FAIL add_pc state=%0d rw=%b pcw=%b exp=8/1/1", State, RegWrite, PCWrite); end
        tick();
        // Unsupported cmd 0011 with I=1: EXECI, ADD, and no writeback.
        Instr = 20'hE261F;
        tick(); tick();
        #1;
        total++; if (State !== 4'd7 || ALUSrcB !== 2'b01 || ALUControl !== 3'b000) begin bad++; $display("FAIL other_execi state=%0d b=%b ctl=%b exp=7/01/000", State, ALUSrcB, ALUControl); end
        tick();
        #1;
        total++; if (State !== 4'd8 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin bad++; $display("FAIL other_nowrite state=%0d rw=%b pcw=%b exp=8/0/0", State, RegWrite, PCWrite); end
        tick();
        // Op=11 undefined: back to FETCH straight after DECODE.
        Instr = 20'hEC000;
        tick();
        #1;
        total++; if (State !== 4'd1 || ImmSrc !== 2'b11 || RegSrc !== 2'b00 || RegWrite !== 1'b0) begin bad++; $display("FAIL undef_decode state=%0d imm=%b rsrc=%b rw=%b exp=1/11/00/0", State, ImmSrc, RegSrc, RegWrite); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL undef_fetch got=%0d exp=0", State); end
    endtask

    task automatic test_reset_mid();
        Instr = 20'hE5850; MemReady = 1'b1;
        tick(); tick();
        MemReady = 1'b0;
        tick();
        #1;
        total++; if (State !== 4'd5 || MemWrite !== 1'b1 || RegSrc !== 2'b10) begin bad++; $display("FAIL str_memwr state=%0d mw=%b rsrc=%b exp=5/1/10", State, MemWrite, RegSrc); end
        #1;
        reset = 1'b1; MemReady = 1'b1;
        #1;
        total++; if (MemWrite !== 1'b0 || State !== 4'd0) begin bad++; $display("FAIL rst_mid mw=%b state=%0d exp=0/0", MemWrite, State); end
        total++; if ({IRWrite, PCWrite} !== 2'b00) begin bad++; $display("FAIL rst_mid_fetch_en got=%b exp=00", {IRWrite, PCWrite}); end
        tick();
        reset = 1'b0;
        // N was set by CMP; after reset the flags are clear so BMI must not take.
        Instr = 20'h4A000;
        tick(); tick();
        #1;
        total++; if (State !== 4'd9 || PCWrite !== 1'b0) begin bad++; $display("FAIL rst_flags_bmi state=%0d pcw=%b exp=9/0", State, PCWrite); end
        tick();
    endtask

    initial begin
        reset = 1'b1; Instr = '0; ALUFlags = '0; MemReady = 1'b0;
        test_reset();
        test_fetch_wait();
        test_add();
        test_subs_beq();
        test_ldrb();
        test_strne();
        test_cmp();
        test_dp_variants();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arm_multicycle_controller.md
Name: arm_multicycle_controller

Overview:
Parametrised multicycle control unit for the next-generation ARM core. It replaces single-cycle control with a Moore FSM that shares one ALU and one memory port across fetch, decode, execute, memory and writeback. It adds memory wait-state handshaking, registered NZCV flags, byte load/store control, and writes to R15. It sits beside the multicycle datapath and drives all of its enables and muxes.

Parameters:
ALUCTRL_W, 3, width of ALUControl.
FLAG_W, 4, width of ALUFlags and of the internal flag register (NZCV, bit 3 = N).
MEM_WAIT_EN, 1, 1: memory states hold until MemReady=1; 0: MemReady is ignored and treated as 1.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
Instr  in  20  Instr[31:12]: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12]; bit 23 = U
ALUFlags  in  FLAG_W  live NZCV from the ALU
MemReady  in  1  memory access completes this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
RegByte  out  1  byte access (B bit) for load/store
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 RD1, 01 PC, 10 ALUOut
ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4
ImmSrc  out  2  equals Op
RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
ALUControl  out  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR
State  out  4  current state, debug

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Any unused encoding goes to FETCH next cycle.
- Reset while asserted: State=FETCH, flag register=0000, all enables (PCWrite, IRWrite, RegWrite, MemWrite) forced to 0. Muxes show FETCH values.
- Reset mid-operation: in-flight writes drop in the same cycle and nothing is committed.
- CondEx: standard ARM table on Cond against the registered flags. Cond=1110 always passes; Cond=1111 is always false.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10.
  - IRWrite and PCWrite are asserted only in a cycle with MemReady=1; the next state is then DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10 (PC+8). Next state:
  - Op=01 -> MEMADR
  - Op=00 and Funct[5]=0 -> EXECR
  - Op=00 and Funct[5]=1 -> EXECI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH (undefined instruction, no side effects)
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD if U=1 else SUB, RegByte=Funct[2]. Next state is MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1, RegByte held. Stays until MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx, RegByte held.
  - If Rd=15, PCWrite=CondEx.
  - Next state FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx, held for every wait cycle. Exits to FETCH on MemReady=1.
- EXECR / EXECI: ALUSrcA=00, ALUSrcB=00 (EXECR) or 01 (EXECI). ALUControl decoded from cmd=Funct[4:1]:
  - 0100 -> ADD, 0010 -> SUB, 0000 -> AND, 1100 -> ORR, 0001 -> EOR
  - 1010 (CMP) -> SUB with NoWrite=1
  - any other cmd -> ADD with NoWrite=1
- Flag update: the flag register loads ALUFlags at the clock edge leaving EXECR/EXECI when Funct[0]=1 and CondEx=1. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite = CondEx & ~NoWrite. PCWrite is asserted as well when Rd=15 with the same gating. Next state FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. Next state FETCH.
- All outputs are combinational from State, Instr and the flag register; there are no glitch-relevant paths to MemReady except the gating described above.
- MEM_WAIT_EN=0: every memory state takes exactly 1 cycle.
- Latencies with zero wait states, in cycles:
  - Data-processing: 4
  - LDR: 5
  - STR: 4
  - Branch: 3

Test Plan:
- Reset, then ADD R1,R2,R3 (E0821003), MemReady=1 -> states 0,1,6,8,0; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB; flags stay 0000.
- SUBS R0,R1,R1 (E0510001) with ALUFlags=0100, then BEQ (0A000002) -> PCWrite=1 in BRANCH. Repeat with ALUFlags=0000 -> PCWrite=0.
- LDRB R4,[R5,#4] (E5D54004) with MemReady low for 3 cycles in MEMRD -> State=3 for 4 cycles; RegByte=1 in MEMADR through MEMWB; RegWrite=1 in MEMWB only.
- STRNE (15850000) with flag Z=1 -> MEMWR entered, MemWrite=0 throughout, return to FETCH.
- CMP R0,R1 (E1500001) -> ALUControl=001, RegWrite=0 in ALUWB, flag register loaded from ALUFlags.
- Reset asserted during MEMWR with MemReady low -> MemWrite drops the same cycle; State=0 and flags=0000 without waiting for a clock edge.
